// File: rtl/logic_op_sequencer_if.sv
// Valid/ready command and result channels of the 4-bit ALU logic path.
// The stimulus source is the master; the sequencer is the slave.
interface logic_op_sequencer_if #(
   parameter int DATA_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              in_acc_sel;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [2:0]        out_op;
   logic              out_zero;
   logic              out_parity;
   logic              out_err;

   modport master (
      output in_valid, in_op, in_a, in_b, in_acc_sel, out_ready,
      input  in_ready, out_valid, out_result, out_op, out_zero, out_parity, out_err
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_acc_sel, out_ready,
      output in_ready, out_valid, out_result, out_op, out_zero, out_parity, out_err
   );
endinterface

// File: rtl/logic_op_sequencer.sv
// Logic-op command unit: evaluates one of seven bitwise functions per accepted
// command, chains through a 4-bit accumulator and returns a registered result beat.
module logic_op_sequencer #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   logic_op_sequencer_if.slave   bus,
   output logic [DATA_W-1:0]     acc,
   output logic [CNT_W-1:0]      op_count
);

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_NAND = 3'd1,
      OP_OR   = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_ILL  = 3'd7
   } op_e;

   logic              accept;
   logic              legal;
   logic [DATA_W-1:0] eff_a;
   logic [DATA_W-1:0] result;

   // NOTE: in_ready depends on out_ready combinationally so a full output
   // register can drain and take the next command on the same edge.
   assign bus.in_ready = ~rst & (~bus.out_valid | bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready;

   always_comb begin
      eff_a  = bus.in_acc_sel ? acc : bus.in_a;
      result = '0;
      legal  = 1'b1;
      case (op_e'(bus.in_op))
         OP_AND:  result = eff_a & bus.in_b;
         OP_NAND: result = ~(eff_a & bus.in_b);
         OP_OR:   result = eff_a | bus.in_b;
         OP_NOR:  result = ~(eff_a | bus.in_b);
         OP_XOR:  result = eff_a ^ bus.in_b;
         OP_XNOR: result = ~(eff_a ^ bus.in_b);
         OP_NOT:  result = ~eff_a;
         default: legal  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid  <= 1'b0;
         bus.out_result <= '0;
         bus.out_op     <= '0;
         bus.out_zero   <= 1'b0;
         bus.out_parity <= 1'b0;
         bus.out_err    <= 1'b0;
         acc            <= '0;
         op_count       <= '0;
      end else if (accept) begin
         // An illegal op still produces a beat (result 0) but leaves acc/op_count alone.
         bus.out_valid  <= 1'b1;
         bus.out_result <= result;
         bus.out_op     <= bus.in_op;
         bus.out_zero   <= (result == '0);
         bus.out_parity <= ^result;
         bus.out_err    <= ~legal;
         if (legal) begin
            acc <= result;
            if (op_count != '1)
               op_count <= op_count + CNT_W'(1);
         end
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer: vector table for the function/chaining
// path, hand sequences for backpressure, reset mid-beat and counter saturation.
module tb_logic_op_sequencer;

   logic clk = 1'b0;
   logic rst;
   logic rst2;

   always #5 clk = ~clk;

   logic_op_sequencer_if #(.DATA_W(4)) bus ();
   logic_op_sequencer_if #(.DATA_W(4)) bus2 ();
   logic [3:0] acc;
   logic [7:0] op_count;
   logic [3:0] acc2;
   logic [1:0] op_count2;

   logic_op_sequencer #(.DATA_W(4), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .acc      (acc),
      .op_count (op_count)
   );

   logic_op_sequencer #(.DATA_W(4), .CNT_W(2)) dut_sat (
      .clk      (clk),
      .rst      (rst2),
      .bus      (bus2),
      .acc      (acc2),
      .op_count (op_count2)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [2:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic       sel;
      logic [3:0] res;
      logic       zero;
      logic       par;
      logic       err;
      logic [3:0] acc;
      logic [7:0] cnt;
   } vec_t;

   vec_t vecs [15];

   initial begin
      //            op    a     b     sel   res   z     p     e     acc   cnt
      vecs[0]  = '{3'd0, 4'hC, 4'hA, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h8, 8'd1};
      vecs[1]  = '{3'd0, 4'h5, 4'h3, 1'b0, 4'h1, 1'b0, 1'b1, 1'b0, 4'h1, 8'd2};
      vecs[2]  = '{3'd1, 4'h5, 4'h3, 1'b0, 4'hE, 1'b0, 1'b1, 1'b0, 4'hE, 8'd3};
      vecs[3]  = '{3'd2, 4'h5, 4'h3, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0, 4'h7, 8'd4};
      vecs[4]  = '{3'd3, 4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0, 4'h8, 8'd5};
      vecs[5]  = '{3'd4, 4'h5, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 4'h6, 8'd6};
      vecs[6]  = '{3'd5, 4'h5, 4'h3, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 4'h9, 8'd7};
      vecs[7]  = '{3'd6, 4'h5, 4'h3, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0, 4'hA, 8'd8};
      vecs[8]  = '{3'd2, 4'h1, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 4'h3, 8'd9};
      vecs[9]  = '{3'd4, 4'h0, 4'hF, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 4'hC, 8'd10};
      vecs[10] = '{3'd4, 4'h5, 4'h3, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 4'h6, 8'd11};
      vecs[11] = '{3'd7, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h6, 8'd11};
      vecs[12] = '{3'd6, 4'h0, 4'h5, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 4'h9, 8'd12};
      vecs[13] = '{3'd1, 4'h0, 4'hF, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 4'h6, 8'd13};
      vecs[14] = '{3'd0, 4'h0, 4'hF, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 8'd14};

      rst             = 1'b1;
      rst2            = 1'b1;
      bus.in_valid    = 1'b0;
      bus.in_op       = 3'd0;
      bus.in_a        = 4'h0;
      bus.in_b        = 4'h0;
      bus.in_acc_sel  = 1'b0;
      bus.out_ready   = 1'b1;
      bus2.in_valid   = 1'b0;
      bus2.in_op      = 3'd2;
      bus2.in_a       = 4'h1;
      bus2.in_b       = 4'h0;
      bus2.in_acc_sel = 1'b0;
      bus2.out_ready  = 1'b1;

      tick();
      tick();
      check("rst_in_ready", bus.in_ready, 1'b0);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_result", bus.out_result, 4'h0);
      check("rst_flags", {bus.out_zero, bus.out_parity, bus.out_err}, 3'b000);
      check("rst_acc", acc, 4'h0);
      check("rst_op_count", op_count, 8'd0);
      rst  = 1'b0;
      rst2 = 1'b0;

      // Back-to-back accepts, one per cycle, checked one cycle after each accept.
      for (int i = 0; i < 15; i++) begin
         bus.in_valid   = 1'b1;
         bus.in_op      = vecs[i].op;
         bus.in_a       = vecs[i].a;
         bus.in_b       = vecs[i].b;
         bus.in_acc_sel = vecs[i].sel;
         #1;
         check($sformatf("v%0d_in_ready", i), bus.in_ready, 1'b1);
         tick();
         check($sformatf("v%0d_out_valid", i), bus.out_valid, 1'b1);
         check($sformatf("v%0d_out_result", i), bus.out_result, vecs[i].res);
         check($sformatf("v%0d_out_op", i), bus.out_op, vecs[i].op);
         check($sformatf("v%0d_out_zero", i), bus.out_zero, vecs[i].zero);
         check($sformatf("v%0d_out_parity", i), bus.out_parity, vecs[i].par);
         check($sformatf("v%0d_out_err", i), bus.out_err, vecs[i].err);
         check($sformatf("v%0d_acc", i), acc, vecs[i].acc);
         check($sformatf("v%0d_op_count", i), op_count, vecs[i].cnt);
      end

      // Idle cycle drains the beat; data fields hold.
      bus.in_valid = 1'b0;
      tick();
      check("drain_out_valid", bus.out_valid, 1'b0);
      check("drain_hold_result", bus.out_result, 4'h0);
      check("drain_hold_zero", bus.out_zero, 1'b1);

      // Backpressure: beat 7 held for three cycles, then drain + accept on one edge.
      bus.in_valid   = 1'b1;
      bus.in_op      = 3'd2;
      bus.in_a       = 4'h3;
      bus.in_b       = 4'h4;
      bus.in_acc_sel = 1'b0;
      tick();
      check("bp_first_result", bus.out_result, 4'h7);
      bus.in_op     = 3'd0;
      bus.in_a      = 4'hF;
      bus.in_b      = 4'hF;
      bus.out_ready = 1'b0;
      #1;
      check("bp_in_ready", bus.in_ready, 1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check($sformatf("bp%0d_in_ready", c), bus.in_ready, 1'b0);
         check($sformatf("bp%0d_out_valid", c), bus.out_valid, 1'b1);
         check($sformatf("bp%0d_out_result", c), bus.out_result, 4'h7);
         check($sformatf("bp%0d_out_op", c), bus.out_op, 3'd2);
         check($sformatf("bp%0d_acc", c), acc, 4'h7);
         check($sformatf("bp%0d_op_count", c), op_count, 8'd15);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", bus.in_ready, 1'b1);
      tick();
      check("bp_next_out_valid", bus.out_valid, 1'b1);
      check("bp_next_out_result", bus.out_result, 4'hF);
      check("bp_next_out_op", bus.out_op, 3'd0);
      check("bp_next_acc", acc, 4'hF);
      check("bp_next_op_count", op_count, 8'd16);

      // Reset while a beat is stalled drops it and clears state.
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      check("pre_rst_out_valid", bus.out_valid, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", bus.in_ready, 1'b0);
      tick();
      rst = 1'b0;
      check("post_rst_out_valid", bus.out_valid, 1'b0);
      check("post_rst_acc", acc, 4'h0);
      check("post_rst_op_count", op_count, 8'd0);
      check("post_rst_out_result", bus.out_result, 4'h0);

      // Two-bit counter saturates at 3 and never wraps.
      bus2.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("sat%0d_op_count", k), op_count2, (k < 3) ? k + 1 : 3);
         check($sformatf("sat%0d_out_result", k), bus2.out_result, 4'h1);
      end
      bus2.in_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/logic_op_sequencer.md
Name: logic_op_sequencer

Overview:
- Front-end command unit for the 4-bit ALU logic path.
- Accepts logic-op commands over a valid/ready interface and evaluates one of seven bitwise functions: AND, NAND, OR, NOR, XOR, XNOR, NOT A.
- Keeps a 4-bit accumulator so ops can be chained, and returns a registered result with zero/parity flags over a valid/ready output.
- Sits between the instruction/stimulus source and the ALU result bus; it is the issuing and consuming end of the logic-function interface.

Parameters:
- DATA_W, 4, operand/result/accumulator width.
- CNT_W, 8, width of the accepted-op counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid & in_ready.
- in_op  input  3  0=AND, 1=NAND, 2=OR, 3=NOR, 4=XOR, 5=XNOR, 6=NOT A, 7=illegal.
- in_a  input  DATA_W  operand A (ignored when in_acc_sel=1).
- in_b  input  DATA_W  operand B (ignored for op 6).
- in_acc_sel  input  1  1: use accumulator as operand A.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts when out_valid & out_ready.
- out_result  output  DATA_W  function result.
- out_op  output  3  opcode of the result beat.
- out_zero  output  1  out_result == 0.
- out_parity  output  1  XOR-reduce of out_result.
- out_err  output  1  beat came from illegal op 7.
- acc  output  DATA_W  current accumulator value.
- op_count  output  CNT_W  number of accepted legal ops, saturating.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): out_valid=0, out_result=0, out_op=0, out_zero=0, out_parity=0, out_err=0, acc=0, op_count=0.
- in_ready is combinational: in_ready = ~rst & (~out_valid | out_ready).
- No combinational path from in_* to out_*.
- Accept: the edge where in_valid & in_ready.
  - Effective A = in_acc_sel ? acc : in_a.
  - Result = selected function of effective A and in_b, bitwise, DATA_W bits, no carries. NOT ignores in_b.
- On accept of a legal op (0–6), at the same edge:
  - out_result <= result; out_op <= in_op; out_err <= 0.
  - out_zero and out_parity are computed from the new result.
  - out_valid <= 1.
  - acc <= result.
  - op_count <= op_count + 1, saturating at 2^CNT_W - 1.
- On accept of op 7:
  - out_result <= 0; out_op <= 7; out_err <= 1; out_zero <= 1; out_parity <= 0; out_valid <= 1.
  - acc and op_count are unchanged.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 op/cycle while out_ready=1.
- Output handshake:
  - No accept and out_valid & out_ready: out_valid <= 0; data fields hold their last value.
  - Accept and drain in the same cycle: the new beat replaces the old one and out_valid stays 1.
- Backpressure (out_valid=1, out_ready=0):
  - in_ready=0.
  - All out_* fields, acc and op_count hold stable until drained.
- Chaining: back-to-back in_acc_sel=1 ops each see the acc written by the previous accept. acc updates at the accept edge, so no bubble is needed.
- in_valid=1 with in_ready=0: no state change. The source must hold its command stable.
- Reset mid-operation: any pending out beat is dropped, acc=0, op_count=0, and in_ready=0 during the rst cycle.
- Counter saturation: op_count stays at its max value and never wraps.

Test Plan:
- Reset, then in_op=0, in_a=4'hC, in_b=4'hA, out_ready=1 -> next cycle out_valid=1, out_result=4'h8, out_zero=0, out_parity=1, acc=4'h8, op_count=1.
- Sweep ops 0–6 back-to-back with in_a=4'h5, in_b=4'h3, out_ready=1 -> out_result sequence 1, E, 7, 8, 6, 9, A. One result per cycle, in_ready held at 1, op_count=7.
- Chaining: in_op=2, in_a=4'h1, in_b=4'h2, then in_acc_sel=1 with in_op=4 and in_b=4'hF -> second result 4'hC, acc=4'hC.
- Backpressure: hold out_ready=0 for 3 cycles after a beat -> in_ready=0, and out_result/acc/op_count stable. Release -> beat drains and the next command is accepted in the same cycle.
- Illegal op 7 with acc=4'h6 -> out_err=1, out_result=0, out_zero=1, acc stays 6, op_count unchanged. The next legal op gives out_err=0.
- Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, acc=0, op_count=0. With CNT_W=2, 5 legal ops -> op_count=3 (saturated).
